// File: rtl/fifo_pair_reader.sv
// Read-side client of the operand FIFO: pops A/B word pairs and hands them to the MAC over valid/ready.
// Optional FP16_ZERO_SKIP_EN drops any pair with a +/-0 operand instead of presenting it.
module fifo_pair_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_last
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    LAT_A   = 3'd2,
    FETCH_B = 3'd3,
    LAT_B   = 3'd4,
    PRESENT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic                 last_pair;
  logic                 fetching;

  // len_q is never zero while a vector is in flight, so len_q-1 cannot underflow.
  assign last_pair = (cnt_q == (len_q - LEN_WIDTH'(1)));
  assign fetching  = (state == FETCH_A) || (state == FETCH_B);

  // All outputs decode directly from registered state, so reset clears them asynchronously.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == PRESENT);
  assign out_last  = out_valid && last_pair;
  assign fifo_r_en = fetching && !fifo_empty;

`ifdef FP16_ZERO_SKIP_EN
  logic zero_pair;
  assign zero_pair = (out_a[DATA_WIDTH-2:0] == '0) || (fifo_data[DATA_WIDTH-2:0] == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out_a <= '0;
      out_b <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (vec_len != '0) begin
              len_q <= vec_len;
              cnt_q <= '0;
              state <= FETCH_A;
            end else begin
              state <= DONE;
            end
          end
        end
        FETCH_A: begin
          if (!fifo_empty) state <= LAT_A;
        end
        LAT_A: begin
          out_a <= fifo_data;
          state <= FETCH_B;
        end
        FETCH_B: begin
          if (!fifo_empty) state <= LAT_B;
        end
        LAT_B: begin
          out_b <= fifo_data;
`ifdef FP16_ZERO_SKIP_EN
          if (zero_pair) begin
            cnt_q <= cnt_q + LEN_WIDTH'(1);
            state <= last_pair ? DONE : FETCH_A;
          end else begin
            state <= PRESENT;
          end
`else
          state <= PRESENT;
`endif
        end
        PRESENT: begin
          // Pair and last flag stay frozen until the MAC takes them.
          if (out_ready) begin
            cnt_q <= cnt_q + LEN_WIDTH'(1);
            state <= last_pair ? DONE : FETCH_A;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_pair_reader.md
Name: fifo_pair_reader

Overview:
- Read-side client of the operand FIFO in the FP16 MAC datapath.
- On `start`, pops `vec_len` operand pairs from the FIFO and presents each pair to the MAC input over a valid/ready handshake.
- Pair order within the FIFO is A then B.
- Flags the final pair with `out_last`, then pulses `done`.

Parameters:
- DATA_WIDTH, 16, width of one FIFO word / FP16 operand.
- LEN_WIDTH, 10, width of the vector-length (pair count) field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start  input  1  begin a vector; sampled only in IDLE.
- vec_len  input  LEN_WIDTH  number of pairs; latched when start is accepted.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the final pair completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_en  output  1  FIFO pop request.
- fifo_data  input  DATA_WIDTH  FIFO read data; registered, valid the cycle after an accepted pop.
- out_valid  output  1  operand pair valid to MAC.
- out_ready  input  1  MAC accepts the pair.
- out_a  output  DATA_WIDTH  operand A.
- out_b  output  DATA_WIDTH  operand B.
- out_last  output  1  high with the final pair of the vector.

Behaviour:
- Reset, asynchronous, any state:
  - state = IDLE.
  - busy, done, fifo_r_en, out_valid and out_last = 0.
  - out_a, out_b, pair counter and latched length = 0.
  - A pop in flight is discarded.
- States: IDLE, FETCH_A, LAT_A, FETCH_B, LAT_B, PRESENT, DONE.
- IDLE:
  - start=1 and vec_len != 0: latch vec_len, clear counter, go to FETCH_A.
  - start=1 and vec_len == 0: go to DONE; no FIFO reads.
- FETCH_A:
  - fifo_r_en = !fifo_empty, combinational.
  - If !fifo_empty, go to LAT_A; otherwise stay (stall, no pop).
- LAT_A: capture fifo_data into out_a at the cycle's end; go to FETCH_B.
- FETCH_B / LAT_B: same as FETCH_A / LAT_A, capturing into out_b; LAT_B goes to PRESENT.
- PRESENT:
  - out_valid = 1.
  - out_a, out_b and out_last held stable until out_valid & out_ready.
  - out_last = 1 when counter == latched length - 1.
  - On handshake:
    - counter increments.
    - If last, go to DONE; otherwise go to FETCH_A.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- fifo_r_en is never asserted outside FETCH_A/FETCH_B, never while fifo_empty=1, and at most once per fetch state visit.
- Latency: with the FIFO non-empty and out_ready=1, start sampled at cycle 0 gives out_valid at cycle 5. Each further pair takes 5 cycles. done asserts the cycle after the final handshake.
- start while busy is ignored. vec_len changes after acceptance have no effect.
- Maximum vector is 2^LEN_WIDTH-1 pairs; the counter never wraps within a vector.
- The FIFO stalling between A and B (empty in FETCH_B) holds out_a and waits; no partial pair is ever presented.

Optional Feature:
- Macro: FP16_ZERO_SKIP_EN.
- Defined:
  - In LAT_B, if out_a[14:0]==0 or captured B[14:0]==0 (±0 operand), the pair is dropped: no PRESENT, counter increments, next state is FETCH_A (or DONE if it was the last pair).
  - A dropped final pair means no out_last beat for that vector; done still pulses.
- Undefined: every pair is presented, with no operand inspection.

Test Plan:
- FIFO preloaded with 0x3C00, 0x4000; vec_len=1; start; out_ready=1 -> fifo_r_en high cycles 1 and 3; out_valid at cycle 5 with out_a=0x3C00, out_b=0x4000, out_last=1; done at cycle 6; busy low at cycle 7.
- vec_len=3, six words 0x3C00..0x3C05, out_ready toggling 1/0 -> pairs (0x3C00,0x3C01), (0x3C02,0x3C03), (0x3C04,0x3C05) in order; outputs stable while out_ready=0; out_last only on the third pair.
- fifo_empty held 1 for 4 cycles between the A and B words -> fifo_r_en stays 0 during the stall; out_valid not asserted until B is captured; A unchanged.
- vec_len=0 and start -> done pulses at cycle 1; fifo_r_en never asserted; out_valid stays 0.
- rst_n dropped while in PRESENT with out_valid=1 -> all outputs 0 asynchronously; a following start works normally.
- FP16_ZERO_SKIP_EN defined, pairs (0x8000,0x3C00), (0x4000,0x4200), vec_len=2 -> only (0x4000,0x4200) presented, with out_last=1; done follows.
